nes_joypad: RTL and testbench

NES_JOYPAD -- requirements
Module: nes_joypad

---
 rtl/nes_joypad_pkg.sv | 47 ++++
 rtl/nes_joypad_if.sv | 13 +
 rtl/nes_key_decode.sv | 35 +++
 rtl/nes_joypad.sv | 81 ++++++++
 tb/tb_nes_joypad.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/nes_joypad_pkg.sv
// Shared constants for the NES joypad bridge: button bit order, USB HID key map
// and CPU select encodings.
package nes_joypad_pkg;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam logic [7:0] KEY_K      = 8'h0E;
  localparam logic [7:0] KEY_J      = 8'h0D;
  localparam logic [7:0] KEY_TAB    = 8'h2B;
  localparam logic [7:0] KEY_ENTER  = 8'h28;
  localparam logic [7:0] KEY_W      = 8'h1A;
  localparam logic [7:0] KEY_S      = 8'h16;
  localparam logic [7:0] KEY_A      = 8'h04;
  localparam logic [7:0] KEY_D      = 8'h07;

  localparam logic [7:0] KEY_PERIOD = 8'h37;
  localparam logic [7:0] KEY_COMMA  = 8'h36;
  localparam logic [7:0] KEY_MINUS  = 8'h2D;
  localparam logic [7:0] KEY_EQUALS = 8'h2E;
  localparam logic [7:0] KEY_UP     = 8'h52;
  localparam logic [7:0] KEY_DOWN   = 8'h51;
  localparam logic [7:0] KEY_LEFT   = 8'h50;
  localparam logic [7:0] KEY_RIGHT  = 8'h4F;

  // Key tables: byte n holds the keycode for button bit n.
  localparam logic [63:0] PAD1_KEYS = {KEY_D, KEY_A, KEY_S, KEY_W,
                                       KEY_ENTER, KEY_TAB, KEY_J, KEY_K};
  localparam logic [63:0] PAD2_KEYS = {KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP,
                                       KEY_EQUALS, KEY_MINUS, KEY_COMMA, KEY_PERIOD};

  localparam logic [7:0] OPEN_BUS_DEFAULT = 8'h40;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_P1   = 2'b01,
    SEL_P2   = 2'b10,
    SEL_BAD  = 2'b11
  } joy_sel_e;

endpackage

// File: rtl/nes_joypad_if.sv
// CPU-side register bus for the $4016/$4017 joypad ports.
interface nes_joypad_if;
  logic       cpu_ce;
  logic       cpu_we;
  logic [1:0] cpu_sel;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;

  modport master (output cpu_ce, output cpu_we, output cpu_sel, output cpu_wdata,
                  input  cpu_rdata);
  modport slave  (input  cpu_ce, input  cpu_we, input  cpu_sel, input  cpu_wdata,
                  output cpu_rdata);
endinterface

// File: rtl/nes_key_decode.sv
// Maps four HID keycode slots onto one pad's 8 button bits, cancelling
// opposing directions.
module nes_key_decode
  import nes_joypad_pkg::*;
#(
  parameter logic [63:0] KEYS = PAD1_KEYS
) (
  input  logic [31:0] i_keycode,
  output logic [7:0]  o_pad
);

  logic [7:0] w_hit;

  always_comb begin
    w_hit = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      for (int unsigned s = 0; s < 4; s++) begin
        if (i_keycode[s*8 +: 8] == KEYS[b*8 +: 8]) w_hit[b] = 1'b1;
      end
    end
  end

  always_comb begin
    o_pad = w_hit;
    if (w_hit[BTN_UP] && w_hit[BTN_DOWN]) begin
      o_pad[BTN_UP]   = 1'b0;
      o_pad[BTN_DOWN] = 1'b0;
    end
    if (w_hit[BTN_LEFT] && w_hit[BTN_RIGHT]) begin
      o_pad[BTN_LEFT]  = 1'b0;
      o_pad[BTN_RIGHT] = 1'b0;
    end
  end

endmodule

// File: rtl/nes_joypad.sv
// Keyboard-to-NES joypad bridge: synchronises HID keycodes, decodes two pads
// and serves them through the $4016/$4017 strobe/shift protocol.
module nes_joypad
  import nes_joypad_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  OPEN_BUS    = OPEN_BUS_DEFAULT
) (
  input  logic         Clk,
  input  logic         reset_n,
  input  logic [31:0]  keycode,
  nes_joypad_if.slave  bus,
  output logic [15:0]  btn_live
);

  logic [31:0] r_sync [SYNC_STAGES];
  logic [15:0] r_btn;
  logic        r_strobe;
  logic [7:0]  r_sh1;
  logic [7:0]  r_sh2;
  logic [7:0]  w_pad1;
  logic [7:0]  w_pad2;
  logic        w_rd;
  logic        w_wr;

  assign w_rd     = bus.cpu_ce && !bus.cpu_we;
  assign w_wr     = bus.cpu_ce &&  bus.cpu_we;
  assign btn_live = r_btn;

  nes_key_decode #(.KEYS(PAD1_KEYS)) u_dec_p1 (
    .i_keycode (r_sync[SYNC_STAGES-1]),
    .o_pad     (w_pad1)
  );

  nes_key_decode #(.KEYS(PAD2_KEYS)) u_dec_p2 (
    .i_keycode (r_sync[SYNC_STAGES-1]),
    .o_pad     (w_pad2)
  );

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_btn <= '0;
    end else begin
      r_sync[0] <= keycode;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_btn <= {w_pad2, w_pad1};
    end
  end

  // Reload uses the strobe value before this edge, so the 1->0 write still
  // captures the current btn_live.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_strobe <= 1'b0;
      r_sh1    <= '0;
      r_sh2    <= '0;
    end else begin
      if (w_wr && bus.cpu_sel == SEL_P1) r_strobe <= bus.cpu_wdata[0];
      if (r_strobe) begin
        r_sh1 <= r_btn[7:0];
        r_sh2 <= r_btn[15:8];
      end else if (w_rd) begin
        if (bus.cpu_sel == SEL_P1) r_sh1 <= {1'b1, r_sh1[7:1]};
        if (bus.cpu_sel == SEL_P2) r_sh2 <= {1'b1, r_sh2[7:1]};
      end
    end
  end

  always_comb begin
    bus.cpu_rdata = '0;
    if (w_rd) begin
      case (bus.cpu_sel)
        SEL_P1:  bus.cpu_rdata = OPEN_BUS | {7'b0, r_sh1[0]};
        SEL_P2:  bus.cpu_rdata = OPEN_BUS | {7'b0, r_sh2[0]};
        default: bus.cpu_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_joypad.sv
// Scoreboard bench for nes_joypad: stimulus queues expected read data and
// btn_live values; a negedge monitor pops and compares.
module tb_nes_joypad;

  typedef struct {
    bit          is_live;
    logic [15:0] val;
    string       name;
  } exp_t;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] keycode = '0;
  logic [15:0] btn_live;
  logic        live_req = 1'b0;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  nes_joypad_if bus();

  nes_joypad #(.SYNC_STAGES(2), .OPEN_BUS(8'h40)) dut (
    .Clk      (Clk),
    .reset_n  (reset_n),
    .keycode  (keycode),
    .bus      (bus.slave),
    .btn_live (btn_live)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    exp_t e;
    if (bus.cpu_ce && !bus.cpu_we) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: rdata=%h with empty scoreboard", bus.cpu_rdata);
      end else begin
        e = q.pop_front();
        if (e.is_live || bus.cpu_rdata !== e.val[7:0]) begin
          n_fail++;
          $display("FAIL %s: rdata got %h expected %h", e.name, bus.cpu_rdata, e.val[7:0]);
        end
      end
    end
    if (live_req) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_live: btn_live=%h with empty scoreboard", btn_live);
      end else begin
        e = q.pop_front();
        if (!e.is_live || btn_live !== e.val) begin
          n_fail++;
          $display("FAIL %s: btn_live got %h expected %h", e.name, btn_live, e.val);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic bus_cyc(input logic we, input logic [1:0] sel, input logic [7:0] wd);
    bus.cpu_ce = 1'b1; bus.cpu_we = we; bus.cpu_sel = sel; bus.cpu_wdata = wd;
    @(posedge Clk); #1;
    bus.cpu_ce = 1'b0; bus.cpu_we = 1'b0; bus.cpu_sel = 2'b00; bus.cpu_wdata = '0;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] wd);
    bus_cyc(1'b1, sel, wd);
  endtask

  task automatic rd(input logic [1:0] sel, input logic [7:0] exp, input string name);
    exp_t e;
    e.is_live = 1'b0; e.val = {8'h00, exp}; e.name = name;
    q.push_back(e);
    bus_cyc(1'b0, sel, 8'h00);
  endtask

  task automatic chk_live(input logic [15:0] exp, input string name);
    exp_t e;
    e.is_live = 1'b1; e.val = exp; e.name = name;
    q.push_back(e);
    live_req = 1'b1;
    @(posedge Clk); #1;
    live_req = 1'b0;
  endtask

  task automatic strobe_pulse();
    wr(2'b01, 8'h01);
    wr(2'b01, 8'h00);
  endtask

  logic [7:0] seq35_p2 [8] = '{8'h41, 8'h40, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40};

  initial begin
    bus.cpu_ce = 1'b0; bus.cpu_we = 1'b0; bus.cpu_sel = 2'b00; bus.cpu_wdata = '0;
    idle(3);
    chk_live(16'h0000, "reset_live");
    reset_n = 1'b1;
    idle(1);

    // Reads after reset with no strobe: eight zeros then ones.
    for (int i = 0; i < 8; i++) rd(2'b01, 8'h40, "post_reset_p1");
    rd(2'b01, 8'h41, "post_reset_p1_ninth");
    rd(2'b10, 8'h40, "post_reset_p2");

    // Single A key on pad 1.
    keycode = 32'h0000000E;
    idle(4);
    chk_live(16'h0001, "live_A");
    strobe_pulse();
    rd(2'b01, 8'h41, "p1_A_bit0");
    for (int i = 1; i < 8; i++) rd(2'b01, 8'h40, "p1_A_rest");
    rd(2'b01, 8'h41, "p1_A_ninth");
    rd(2'b01, 8'h41, "p1_A_tenth");

    // Up+Down cancel, Right kept.
    keycode = 32'h1A160700;
    idle(4);
    chk_live(16'h0080, "live_updown_cancel");

    // Left+Right cancel on pad 2, Start kept; duplicated codes.
    keycode = 32'h504F2E00;
    idle(4);
    chk_live(16'h0800, "live_leftright_cancel");
    keycode = 32'h0E0E0E0E;
    idle(4);
    chk_live(16'h0001, "live_duplicates");

    // Pad 2 Up + A, alternating reads.
    keycode = 32'h52370000;
    idle(4);
    chk_live(16'h1100, "live_p2_upA");
    strobe_pulse();
    for (int i = 0; i < 8; i++) begin
      rd(2'b01, 8'h40, "alt_p1");
      rd(2'b10, seq35_p2[i], "alt_p2");
    end

    // Strobe held high: no shifting, follows live state.
    keycode = 32'h00000000;
    idle(4);
    wr(2'b01, 8'h01);
    idle(1);
    rd(2'b01, 8'h40, "strobe_hi_before");
    keycode = 32'h0000000E;
    idle(4);
    rd(2'b01, 8'h41, "strobe_hi_after");
    rd(2'b01, 8'h41, "strobe_hi_noshift");
    wr(2'b01, 8'h00);
    rd(2'b01, 8'h41, "strobe_release_b0");
    rd(2'b01, 8'h40, "strobe_release_b1");

    // Reset mid-sequence.
    strobe_pulse();
    rd(2'b01, 8'h41, "pre_rst_r0");
    rd(2'b01, 8'h40, "pre_rst_r1");
    rd(2'b01, 8'h40, "pre_rst_r2");
    reset_n = 1'b0;
    chk_live(16'h0000, "live_in_reset");
    reset_n = 1'b1;
    chk_live(16'h0000, "live_after_reset");
    rd(2'b01, 8'h40, "read_after_reset");
    idle(4);
    chk_live(16'h0001, "live_refilled");

    // Unaddressed selects and ignored $4017 write.
    strobe_pulse();
    rd(2'b01, 8'h41, "sel_seq_b0");
    rd(2'b11, 8'h00, "sel_11_read");
    rd(2'b00, 8'h00, "sel_00_read");
    wr(2'b11, 8'h01);
    wr(2'b10, 8'h01);
    for (int i = 1; i < 8; i++) rd(2'b01, 8'h40, "sel_seq_rest");
    rd(2'b01, 8'h41, "sel_seq_ninth");

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge Clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
